// File: rtl/mem_req_ctrl.sv
// Valid/ready request front end for the single-port word memory.
// Sequences reads, full writes and read-modify-write partial writes; one request in flight.
module mem_req_ctrl #(
    parameter  int DEPTH  = 256,
    parameter  int WIDTH  = 32,
    localparam int NBE    = WIDTH / 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int ADDR_W = AW + $clog2(NBE)
) (
    input  logic              clk_i,
    input  logic              aresetn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [WIDTH-1:0]  req_wdata_i,
    input  logic [NBE-1:0]    req_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_we_o,
    output logic [WIDTH-1:0]  rsp_rdata_o,
    output logic              mem_rw_en_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    input  logic [WIDTH-1:0]  mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t             state_q;
    logic               we_q;
    logic [AW-1:0]      addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [NBE-1:0]     be_q;
    logic [WIDTH-1:0]   merged_q;
    logic [WIDTH-1:0]   merged_d;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_rdata_q;
    logic               mem_we_q;
    logic               unused_lsb_s;

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] new_word,
        input logic [WIDTH-1:0] old_word,
        input logic [NBE-1:0]   be
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NBE; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    assign merged_d     = merge_bytes(wdata_q, mem_rdata_i, be_q);
    assign unused_lsb_s = ^req_addr_i[$clog2(NBE)-1:0];

    assign req_ready_o = (state_q == IDLE) && aresetn_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_we_o    = we_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_rw_en_o = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = merged_q;

    // Request sequencing FSM with all outputs held in registers.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            merged_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        addr_q      <= req_addr_i[ADDR_W-1 -: AW];
                        wdata_q     <= req_wdata_i;
                        be_q        <= req_be_i;
                        rsp_rdata_q <= '0;
                        // Full and zero-enable writes skip the read and use RD_WAIT as their
                        // decode slot; an all-ones merge there reduces to the write data.
                        if (req_we_i && ((req_be_i == {NBE{1'b1}}) || (req_be_i == '0))) begin
                            state_q <= RD_WAIT;
                        end else begin
                            state_q <= RD;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (!we_q) begin
                        rsp_rdata_q <= mem_rdata_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (be_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        merged_q <= merged_d;
                        mem_we_q <= 1'b1;
                        state_q  <= WR;
                    end
                end
                WR: begin
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural single-port memory attached.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        aresetn_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [9:0]  req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_be_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic        rsp_we_o;
    logic [31:0] rsp_rdata_o;
    logic        mem_rw_en_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    typedef struct {
        logic        we;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          acc_cnt = 0;
    int          wr_cnt = 0;
    logic [7:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic        prev_valid = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] mem_rd_q;

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .clk_i      (clk),
        .aresetn_i  (aresetn_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_we_i   (req_we_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_be_i   (req_be_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_we_o   (rsp_we_o),
        .rsp_rdata_o(rsp_rdata_o),
        .mem_rw_en_o(mem_rw_en_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // Memory array write port.
    always @(posedge clk) begin
        if (aresetn_i && mem_rw_en_o) mem[mem_addr_o] <= mem_wdata_o;
    end

    // Registered memory read port sharing the controller reset.
    always @(posedge clk or negedge aresetn_i) begin
        if (!aresetn_i) mem_rd_q <= '0;
        else            mem_rd_q <= mem[mem_addr_o];
    end
    assign mem_rdata_i = mem_rd_q;

    // Edge counter and accept tracker.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid_i && req_ready_o) begin
            acc_cyc <= cyc;
            acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each new response.
    always @(negedge clk) begin
        if (mem_rw_en_o) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = mem_addr_o;
            last_wr_data = mem_wdata_o;
        end
        if (rsp_valid_o && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_we", {31'd0, rsp_we_o}, {31'd0, e.we});
                chk("rsp_rdata", rsp_rdata_o, e.rd);
                chk("rsp_latency", 32'(cyc - 1 - acc_cyc), 32'(e.lat));
            end
        end
        prev_valid = rsp_valid_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid_o) && n < 30) begin
            tick();
            n++;
        end
        chk("rsp_timeout", {31'd0, (n < 30)}, 32'd1);
    endtask

    task automatic drive(input logic we, input logic [9:0] a, input logic [31:0] wd, input logic [3:0] be);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_be_i    = be;
    endtask

    task automatic send(input logic we, input logic [9:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] erd, input int lat, input int ewr);
        int w0;
        w0 = wr_cnt;
        chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        drive(we, a, wd, be);
        sb.push_back('{we, erd, lat});
        tick();
        req_valid_i = 1'b0;
        wait_done();
        chk("wr_pulses", 32'(wr_cnt - w0), 32'(ewr));
    endtask

    initial begin
        int a0;
        int w0;
        int n;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
            chk("rst_rsp_we", {31'd0, rsp_we_o}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
            chk("rst_mem_rw_en", {31'd0, mem_rw_en_o}, 32'd0);
            chk("rst_mem_addr", {24'd0, mem_addr_o}, 32'd0);
            chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        end
        aresetn_i = 1'b1;
        tick();
        chk("ready_after_rst", {31'd0, req_ready_o}, 32'd1);

        send(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0, 2, 1);
        chk("full_wr_addr", {24'd0, last_wr_addr}, 32'd4);
        chk("full_wr_data", last_wr_data, 32'hDEADBEEF);
        send(1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, 2, 0);

        send(1'b1, 10'h010, 32'h11223344, 4'hF, 32'h0, 2, 1);
        send(1'b1, 10'h011, 32'h0000AB00, 4'h2, 32'h0, 3, 1);
        chk("rmw_wr_addr", {24'd0, last_wr_addr}, 32'd4);
        chk("rmw_wr_data", last_wr_data, 32'h1122AB44);
        chk("rmw_mem_word", mem[4], 32'h1122AB44);
        send(1'b0, 10'h011, 32'h0, 4'h0, 32'h1122AB44, 2, 0);

        send(1'b1, 10'h010, 32'hFFFFFFFF, 4'h0, 32'h0, 1, 0);
        send(1'b0, 10'h010, 32'h0, 4'hF, 32'h1122AB44, 2, 0);

        send(1'b1, 10'h01C, 32'hA5A5A5A5, 4'hF, 32'h0, 2, 1);
        send(1'b1, 10'h01F, 32'h11223344, 4'h9, 32'h0, 3, 1);
        send(1'b0, 10'h01C, 32'h0, 4'h0, 32'h11A5A544, 2, 0);

        rsp_ready_i = 1'b0;
        drive(1'b0, 10'h010, 32'h0, 4'h0);
        sb.push_back('{1'b0, 32'h1122AB44, 2});
        tick();
        req_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk("bp_rsp_seen", {31'd0, rsp_valid_o}, 32'd1);
        drive(1'b0, 10'h01C, 32'h0, 4'h0);
        sb.push_back('{1'b0, 32'h11A5A544, 2});
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", {31'd0, rsp_valid_o}, 32'd1);
            chk("bp_rdata_hold", rsp_rdata_o, 32'h1122AB44);
            chk("bp_ready_low", {31'd0, req_ready_o}, 32'd0);
            tick();
        end
        chk("bp_no_accept", 32'(acc_cnt - a0), 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        chk("bp_hs_valid_low", {31'd0, rsp_valid_o}, 32'd0);
        chk("bp_hs_ready_high", {31'd0, req_ready_o}, 32'd1);
        chk("bp_hs_no_accept", 32'(acc_cnt - a0), 32'd0);
        tick();
        chk("bp_accept_next", 32'(acc_cnt - a0), 32'd1);
        req_valid_i = 1'b0;
        wait_done();

        w0 = wr_cnt;
        drive(1'b1, 10'h010, 32'h000000FF, 4'h1);
        tick();
        req_valid_i = 1'b0;
        tick();
        aresetn_i = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("mid_rst_wen", {31'd0, mem_rw_en_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd0);
        tick();
        tick();
        aresetn_i = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("post_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("mid_rst_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("mid_rst_sb_empty", 32'(sb.size()), 32'd0);
        send(1'b0, 10'h010, 32'h0, 4'h0, 32'h1122AB44, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
